// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NREGS      = 2 ** ADDR_W_DEF;
  localparam int ZERO_REG   = 0;
  localparam int LAST_REG   = NREGS - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; the caller owns the last_grant history.
// Latency: purely combinational.
// Backpressure: enable=0 suppresses all grants; gnt is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Grant a lone requester; on contention favour the one not granted last.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = enable & req[0] & (~req[1] | last_grant);
    gnt[1] = enable & req[1] & (~req[0] | ~last_grant);
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (A) and loader (B), plus a x1..x7 clear engine.
// Latency: accepted write appears on we3/wa3/wd3 the cycle after the handshake.
// Backpressure: ready drops during a clear and in the clr_start cycle; otherwise round-robin.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3
);

  // Highest register index; the clear walks up to it and then stops.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_idx;
  logic              last_grant;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Ready depends only on valid, clr_start, state and last_grant.
  assign arb_en  = (state == IDLE) && !clr_start;
  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign xfer    = gnt[0] | gnt[1];

  rr_arbiter2 u_rr (
    .req        ({b_valid, a_valid}),
    .enable     (arb_en),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Select the address/data of whichever requester won this cycle.
  always_comb begin
    sel_addr = a_addr;
    sel_data = a_data;
    if (gnt[1]) begin
      sel_addr = b_addr;
      sel_data = b_data;
    end
  end

  // Clear FSM, grant history and registered write port. The first clear write is
  // issued on the same edge that enters CLEAR, so clr_idx always names the index on wa3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clr_idx    <= '0;
      last_grant <= 1'b1;
      clr_busy   <= 1'b0;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_idx  <= ADDR_W'(1);
            clr_busy <= 1'b1;
            we3      <= 1'b1;
            wa3      <= ADDR_W'(1);
            wd3      <= '0;
          end else if (xfer) begin
            last_grant <= gnt[1];
            // x0 is hardwired to zero: the handshake completes but nothing is written.
            if (sel_addr != ZERO_IDX) begin
              we3 <= 1'b1;
              wa3 <= sel_addr;
              wd3 <= sel_data;
            end else begin
              we3 <= 1'b0;
            end
          end else begin
            we3 <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state    <= IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
            we3      <= 1'b0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
            we3     <= 1'b1;
            wa3     <= clr_idx + ADDR_W'(1);
            wd3     <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          we3      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter with a stand-in register file and a write-port scoreboard.
// Latency: expects each accepted write on the port one cycle after its handshake.
// Backpressure: exercises contention, clear lockout and reset mid-clear.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0;
  logic [2:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [2:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       we3;
  logic [2:0] wa3;
  logic [7:0] wd3;

  logic [7:0]  rf [8];
  logic [10:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3)
  );

  always #5 clk = ~clk;

  // Stand-in register file (no reset, write on rising edge).
  initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  always @(posedge clk) if (we3 === 1'b1) rf[wa3] <= wd3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every write-port pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got wa3=%0h wd3=%0h expected no write", wa3, wd3);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {29'd0, wa3}, {29'd0, e[10:8]});
        chk("write_data", {24'd0, wd3}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] val);
    for (int r = 1; r < 8; r++) begin
      a_valid = 1'b1; a_addr = 3'(r); a_data = val;
      #1 chk("preload_ready", {31'd0, a_ready}, 32'd1);
      exp_q.push_back({3'(r), val});
      tick();
    end
    a_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset / idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_wa3", {29'd0, wa3}, 32'd0);
    chk("rst_wd3", {24'd0, wd3}, 32'd0);
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    rst = 1'b1;
    tick();

    // Contention: A wins first (last_grant resets to B), then alternate
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_b_ready", {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      exp_q.push_back((i % 2 == 0) ? {3'd1, 8'h11} : {3'd2, 8'h22});
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("rf_x1", {24'd0, rf[1]}, 32'h11);
    chk("rf_x2", {24'd0, rf[2]}, 32'h22);

    // Single write A -> x3 = 0x5A
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A;
    #1 chk("single_a_ready", {31'd0, a_ready}, 32'd1);
    exp_q.push_back({3'd3, 8'h5A});
    tick();
    a_valid = 1'b0;
    chk("single_we3", {31'd0, we3}, 32'd1);
    tick();
    chk("rf_x3", {24'd0, rf[3]}, 32'h5A);
    chk("idle_we3", {31'd0, we3}, 32'd0);

    // x0 drop: handshake completes, no write, last_grant moves to B
    b_valid = 1'b1; b_addr = 3'd0; b_data = 8'hFF;
    #1 chk("x0_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    chk("x0_we3", {31'd0, we3}, 32'd0);
    tick();
    chk("rf_x0", {24'd0, rf[0]}, 32'h00);
    a_valid = 1'b1; a_addr = 3'd5; a_data = 8'h55;
    b_valid = 1'b1; b_addr = 3'd6; b_data = 8'h66;
    #1 chk("after_x0_a_ready", {31'd0, a_ready}, 32'd1);
    exp_q.push_back({3'd5, 8'h55});
    tick();
    a_valid = 1'b0;
    chk("after_x0_b_ready", {31'd0, b_ready}, 32'd1);
    exp_q.push_back({3'd6, 8'h66});
    tick();
    b_valid = 1'b0;
    tick();

    // Clear with a simultaneous A request
    preload(8'hAA);
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h77;
    clr_start = 1'b1;
    #1 chk("clr_a_ready", {31'd0, a_ready}, 32'd0);
    for (int r = 1; r < 8; r++) exp_q.push_back({3'(r), 8'h00});
    tick();
    clr_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk("clr_busy_on", {31'd0, clr_busy}, 32'd1);
      chk("clr_lock_ready", {31'd0, a_ready}, 32'd0);
      tick();
    end
    chk("clr_busy_off", {31'd0, clr_busy}, 32'd0);
    chk("clr_done_a_ready", {31'd0, a_ready}, 32'd1);
    for (int r = 1; r < 8; r++) chk("clr_rf", {24'd0, rf[r]}, 32'h00);
    exp_q.push_back({3'd1, 8'h77});
    tick();
    a_valid = 1'b0;
    tick();

    // Reset after the third clear write
    preload(8'hAA);
    clr_start = 1'b1;
    for (int r = 1; r < 4; r++) exp_q.push_back({3'(r), 8'h00});
    tick();
    clr_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("midclr_we3", {31'd0, we3}, 32'd0);
    chk("midclr_wa3", {29'd0, wa3}, 32'd0);
    chk("midclr_wd3", {24'd0, wd3}, 32'd0);
    chk("midclr_busy", {31'd0, clr_busy}, 32'd0);
    tick();
    rst = 1'b1;
    for (int r = 1; r < 8; r++) chk("midclr_rf", {24'd0, rf[r]}, (r < 4) ? 32'h00 : 32'hAA);
    a_valid = 1'b1; a_addr = 3'd4; a_data = 8'h44;
    #1 chk("midclr_idle_ready", {31'd0, a_ready}, 32'd1);
    exp_q.push_back({3'd4, 8'h44});
    tick();
    a_valid = 1'b0;
    repeat (3) tick();
    chk("rf_x4_final", {24'd0, rf[4]}, 32'h44);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
